// File: rtl/sti_rx_deserializer.sv
// Serial-to-parallel receive stage for the STI serial transmitter bitstream.
// Rebuilds 8/16/24/32-bit words and queues them in a small valid/ready FIFO.
module sti_rx_deserializer #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        so_data,
    input  logic        so_valid,
    input  logic        rx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    output logic [1:0]  rx_len,
    output logic        rx_busy,
    output logic        short_err,
    output logic        ovf_err,
    output logic [7:0]  word_cnt
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    // Assembler state
    logic [0:0]  state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d;
    logic [31:0] shreg_q, shreg_d;
    logic        short_err_q, short_err_d;
    logic        ovf_err_q, ovf_err_d;
    logic [7:0]  word_cnt_q, word_cnt_d;

    // FIFO state
    logic [31:0]        mem_q [Depth];
    logic [31:0]        mem_d [Depth];
    logic [1:0]         len_mem_q [Depth];
    logic [1:0]         len_mem_d [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    // Per-bit working values
    logic [1:0]  cur_len;
    logic        cur_msb;
    logic [31:0] cur_word;
    logic [5:0]  cur_cnt;
    logic [5:0]  n_bits;
    logic [4:0]  bit_idx;
    logic [31:0] word_next;
    logic        push;
    logic [31:0] push_word;
    logic [1:0]  push_len;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic accept;

    // In IDLE the incoming bit starts a fresh word, so config is taken live from the inputs.
    always_comb begin
        cur_len  = len_q;
        cur_msb  = msb_q;
        cur_word = shreg_q;
        cur_cnt  = bit_cnt_q;
        if (state_q == StIdle) begin
            cur_len  = cfg_length;
            cur_msb  = cfg_msb;
            cur_word = '0;
            cur_cnt  = '0;
        end
        n_bits    = ({4'b0000, cur_len} + 6'd1) << 3;
        bit_idx   = cur_msb ? 5'(n_bits - 6'd1 - cur_cnt) : cur_cnt[4:0];
        word_next = cur_word;
        word_next[bit_idx] = so_data;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        msb_d       = msb_q;
        shreg_d     = shreg_q;
        short_err_d = 1'b0;
        push        = 1'b0;
        push_word   = '0;
        push_len    = cur_len;

        if (so_valid) begin
            len_d = cur_len;
            msb_d = cur_msb;
            if (cur_cnt + 6'd1 == n_bits) begin
                push      = 1'b1;
                push_word = word_next;
                state_d   = StIdle;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end else begin
                state_d   = StShift;
                bit_cnt_d = cur_cnt + 6'd1;
                shreg_d   = word_next;
            end
        end else if (state_q == StShift) begin
            // Bitstream stopped mid-word: the partial word is thrown away.
            short_err_d = 1'b1;
            state_d     = StIdle;
            bit_cnt_d   = '0;
            shreg_d     = '0;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = count_q[FIFO_AW];
    assign pop        = !fifo_empty && rx_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign accept     = push && (!fifo_full || pop);

    always_comb begin
        mem_d     = mem_q;
        len_mem_d = len_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_err_d = push && !accept;
        if (accept) begin
            mem_d[wr_ptr_q]     = push_word;
            len_mem_d[wr_ptr_q] = push_len;
            wr_ptr_d            = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        count_d    = count_q + {{FIFO_AW{1'b0}}, accept} - {{FIFO_AW{1'b0}}, pop};
        word_cnt_d = word_cnt_q + {7'd0, accept};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            msb_q       <= 1'b0;
            shreg_q     <= '0;
            short_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            word_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i]     <= '0;
                len_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            shreg_q     <= shreg_d;
            short_err_q <= short_err_d;
            ovf_err_q   <= ovf_err_d;
            word_cnt_q  <= word_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i]     <= mem_d[i];
                len_mem_q[i] <= len_mem_d[i];
            end
        end
    end

    assign rx_valid  = !fifo_empty;
    assign rx_data   = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign rx_len    = fifo_empty ? 2'd0 : len_mem_q[rd_ptr_q];
    assign rx_busy   = (state_q == StShift);
    assign short_err = short_err_q;
    assign ovf_err   = ovf_err_q;
    assign word_cnt  = word_cnt_q;

endmodule
